spi_reg_bridge: RTL and testbench

//  SPI mode-0 slave bridging an external master to a bank of 8-bit registers in the clk domain.

---
 rtl/spi_reg_bridge.sv | 116 +++++++++++
 tb/tb_spi_reg_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave, oversampled in clk, bridging a master to a bank of 8-bit registers
module spi_reg_bridge #(
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    parameter bit         AUTO_INC    = 1'b1,
    parameter logic [7:0] OOR_READ    = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  nCS,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [NUM_REGS*8-1:0] rd_data,
    output logic                  wr_en,
    output logic [6:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  oor_err
);
    localparam logic [7:0] NREG = 8'(NUM_REGS);
    localparam logic [6:0] LAST = 7'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_q, ncs_q, mosi_q;
    logic                   sck_p, ncs_p;
    logic [7:0]             rx_sr, tx_sr, rx_byte, rd_byte;
    logic [2:0]             bit_cnt;
    logic [6:0]             addr, addr_nxt;
    logic                   rw, done, active, rise, fall, in_rng;

    // nCS chain resets low so a reset taken mid-frame cannot fake a chip-select fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= '0;
            ncs_q  <= '0;
            mosi_q <= '0;
            sck_p  <= 1'b0;
            ncs_p  <= 1'b0;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
            ncs_q  <= {ncs_q[SYNC_STAGES-2:0], nCS};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sck_p  <= sck_q[SYNC_STAGES-1];
            ncs_p  <= ncs_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        rise     = sck_q[SYNC_STAGES-1] & ~sck_p;
        fall     = ~sck_q[SYNC_STAGES-1] & sck_p;
        active   = ~ncs_q[SYNC_STAGES-1] & ((state != IDLE) | ncs_p);
        rx_byte  = {rx_sr[6:0], mosi_q[SYNC_STAGES-1]};
        in_rng   = {1'b0, addr} < NREG;
        rd_byte  = in_rng ? rd_data[8*addr +: 8] : OOR_READ;
        addr_nxt = !AUTO_INC ? addr : (in_rng && addr == LAST) ? 7'd0 : addr + 7'd1;
    end

    assign miso = tx_sr[7];
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            addr    <= '0;
            rw      <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            oor_err <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (!active) begin
                state   <= IDLE;
                bit_cnt <= '0;
                done    <= 1'b0;
                tx_sr   <= '0;
            end else begin
                if (state == IDLE)
                    state <= CMD;
                if (rise) begin
                    rx_sr   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    done    <= bit_cnt == 3'd7;
                    if (bit_cnt == 3'd7 && state == DATA) begin
                        if (rw && in_rng) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= rx_byte;
                        end
                        if (rw && !in_rng)
                            oor_err <= 1'b1;
                        addr <= addr_nxt;
                    end else if (bit_cnt == 3'd7) begin
                        state <= DATA;
                        rw    <= rx_byte[7];
                        addr  <= rx_byte[6:0];
                        if ({1'b0, rx_byte[6:0]} >= NREG)
                            oor_err <= 1'b1;
                    end
                end
                // addr was already advanced at the completing rise, so the load reads the next register
                if (fall) begin
                    tx_sr <= done ? (rw ? 8'h00 : rd_byte) : {tx_sr[6:0], 1'b0};
                    done  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: drives two bridges (auto-increment on and off) from one SPI master, checks against a frame-level model
module tb_spi_reg_bridge;
    localparam int N = 16;

    logic           clk = 1'b0, rst = 1'b1, sck = 1'b0, ncs = 1'b1, mosi = 1'b0;
    logic [N*8-1:0] rd_data = '0;
    logic [1:0]     miso_v, wr_en_v, busy_v, oor_v;
    logic [6:0]     wr_addr_v [2];
    logic [7:0]     wr_data_v [2];
    logic [7:0]     txq [$];
    logic [15:0]    wq [$], eq [$];
    logic [1:0]     exp_oor = '0;
    int             nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    spi_reg_bridge #(.NUM_REGS(N), .AUTO_INC(1'b1)) dut0 (
        .clk(clk), .rst(rst), .sck(sck), .nCS(ncs), .mosi(mosi), .miso(miso_v[0]),
        .rd_data(rd_data), .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]),
        .busy(busy_v[0]), .oor_err(oor_v[0]));

    spi_reg_bridge #(.NUM_REGS(N), .AUTO_INC(1'b0)) dut1 (
        .clk(clk), .rst(rst), .sck(sck), .nCS(ncs), .mosi(mosi), .miso(miso_v[1]),
        .rd_data(rd_data), .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]),
        .busy(busy_v[1]), .oor_err(oor_v[1]));

    // every clock with wr_en high is logged, so a stretched strobe shows up as an extra entry
    always @(negedge clk) begin
        if (wr_en_v[0]) wq.push_back({1'b0, wr_addr_v[0], wr_data_v[0]});
        if (wr_en_v[1]) wq.push_back({1'b1, wr_addr_v[1], wr_data_v[1]});
    end

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] r0, output logic [7:0] r1);
        r0 = '0;
        r1 = '0;
        for (int b = 7; b >= 8 - nb; b--) begin
            mosi = tx[b];
            #40 sck = 1'b1;
            r0[b] = miso_v[0];
            r1[b] = miso_v[1];
            #40 sck = 1'b0;
        end
    endtask

    function automatic logic [7:0] reg_val(input logic [6:0] a);
        if (a < N) return rd_data[8*a +: 8];
        return 8'hFF;
    endfunction

    task automatic end_checks(input string name);
        nvec++;
        if (wq.size() != eq.size()) begin
            nerr++;
            $display("FAIL %s strobe count got %0d want %0d", name, wq.size(), eq.size());
        end else begin
            foreach (eq[j]) begin
                nvec++;
                if (wq[j] !== eq[j]) begin
                    nerr++;
                    $display("FAIL %s strobe%0d {inst,addr,data} got %h want %h", name, j, wq[j], eq[j]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (oor_v[i] !== exp_oor[i] || busy_v[i] !== 1'b0) begin
                nerr++;
                $display("FAIL %s inst%0d oor/busy got %b%b want %b0", name, i, oor_v[i], busy_v[i], exp_oor[i]);
            end
        end
        wq.delete();
        eq.delete();
    endtask

    task automatic run_frame(input string name);
        logic [6:0] a [2];
        logic [7:0] r0, r1, e, r;
        logic       rw = 1'b0;
        ncs = 1'b0;
        #80;
        foreach (txq[k]) begin
            spi_bits(txq[k], 8, r0, r1);
            for (int i = 0; i < 2; i++) begin
                e = 8'h00;
                if (k == 0) begin
                    rw   = txq[0][7];
                    a[i] = txq[0][6:0];
                    if (a[i] >= N) exp_oor[i] = 1'b1;
                end else begin
                    if (rw && a[i] < N) eq.push_back({i[0], a[i], txq[k]});
                    else if (rw) exp_oor[i] = 1'b1;
                    else e = reg_val(a[i]);
                    if (i == 0) a[0] = (a[0] == 7'(N - 1)) ? 7'd0 : a[0] + 7'd1;
                end
                r = i == 0 ? r0 : r1;
                nvec++;
                if (r !== e) begin
                    nerr++;
                    $display("FAIL %s inst%0d byte%0d miso got %h want %h", name, i, k, r, e);
                end
            end
        end
        #40 ncs = 1'b1;
        #200;
        end_checks(name);
        txq.delete();
    endtask

    task automatic test_reset();
        #22;
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if ({miso_v[i], wr_en_v[i], busy_v[i], oor_v[i], wr_addr_v[i], wr_data_v[i]} !== '0) begin
                nerr++;
                $display("FAIL reset inst%0d outputs got %b/%b/%b/%b/%h/%h want all zero", i,
                         miso_v[i], wr_en_v[i], busy_v[i], oor_v[i], wr_addr_v[i], wr_data_v[i]);
            end
        end
        rst = 1'b0;
        #40;
    endtask

    task automatic test_write();
        txq = '{8'h81, 8'h5A};
        run_frame("write");
    endtask

    task automatic test_read();
        rd_data[8*3 +: 8] = 8'hA5;
        txq = '{8'h03, 8'h00};
        run_frame("read");
    endtask

    task automatic test_wrap();
        rd_data[8*15 +: 8] = 8'h11;
        rd_data[0 +: 8]    = 8'h22;
        txq = '{8'h0F, 8'h00, 8'h00};
        run_frame("wrap");
    endtask

    task automatic test_range();
        txq = '{8'hA0, 8'h77};
        run_frame("range_wr");
        txq = '{8'h20, 8'h00, 8'h00};
        run_frame("range_rd");
    endtask

    task automatic test_abort();
        logic [7:0] r0, r1;
        ncs = 1'b0;
        #80;
        spi_bits(8'h84, 8, r0, r1);
        spi_bits(8'hFF, 5, r0, r1);
        #40 ncs = 1'b1;
        #200;
        end_checks("abort");
        txq = '{8'h84, 8'h3C};
        run_frame("after_abort");
    endtask

    task automatic test_reset_mid();
        logic [7:0] r0, r1;
        ncs = 1'b0;
        #80;
        spi_bits(8'h85, 8, r0, r1);
        spi_bits(8'h55, 4, r0, r1);
        #11 rst = 1'b1;
        #3;
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (miso_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || wr_en_v[i] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_mid inst%0d miso/busy/wr_en got %b%b%b want 000", i, miso_v[i], busy_v[i], wr_en_v[i]);
            end
        end
        #16 rst = 1'b0;
        exp_oor = '0;
        spi_bits(8'hAA, 8, r0, r1);
        #40 ncs = 1'b1;
        #200;
        end_checks("reset_mid");
        txq = '{8'h86, 8'h99, 8'h42};
        run_frame("after_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            for (int j = 0; j < N; j++) rd_data[8*j +: 8] = 8'($urandom);
            txq.push_back({1'($urandom), 7'($urandom_range(0, 23))});
            for (int j = $urandom_range(0, 3); j > 0; j--) txq.push_back(8'($urandom));
            run_frame("random");
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_range();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
